// File: rtl/accum_8bit_seq.sv
// Sequential 8-bit accumulator fed by an upstream adder's Sum output.
// Define ACCUM_SATURATE_EN to clamp the accumulator at 0xFF instead of wrapping.
module accum_8bit_seq #(
   parameter int LEN_W = 4
) (
   input  logic             Clk,
   input  logic             Rst_n,
   input  logic             Start,
   input  logic [LEN_W-1:0] Len,
   input  logic             In_valid,
   input  logic [7:0]       In_data,
   output logic             In_ready,
   output logic [7:0]       Sum,
   output logic             Cout,
   output logic             Done,
   output logic             Busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nx;
   logic [7:0]       acc;
   logic [7:0]       acc_beat;
   logic             cout_q;
   logic [LEN_W-1:0] cnt;
   logic [8:0]       sum9;
   logic             beat;
   logic             start_ok;
   logic             last_beat;

   assign beat      = In_valid & In_ready;
   assign start_ok  = (state == IDLE) & Start;
   assign last_beat = beat & (cnt == LEN_W'(1));
   assign sum9      = {1'b0, acc} + {1'b0, In_data};

   always_comb begin
`ifdef ACCUM_SATURATE_EN
      // once clamped, the accumulator never leaves 0xFF for the rest of the run
      acc_beat = (sum9[8] || acc == 8'hFF) ? 8'hFF : sum9[7:0];
`else
      acc_beat = sum9[7:0];
`endif
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: begin
            if (Start) begin
               state_nx = (Len == '0) ? DONE : ACCUM;
            end
         end
         ACCUM: begin
            if (last_beat) begin
               state_nx = DONE;
            end
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      In_ready = 1'b0;
      Busy     = 1'b0;
      Done     = 1'b0;
      unique case (state)
         IDLE: begin
            In_ready = 1'b0;
         end
         ACCUM: begin
            In_ready = 1'b1;
            Busy     = 1'b1;
         end
         DONE: begin
            Done = 1'b1;
            Busy = 1'b1;
         end
         default: begin
            In_ready = 1'b0;
         end
      endcase
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         acc    <= 8'h00;
         cout_q <= 1'b0;
         cnt    <= '0;
      end else if (start_ok) begin
         acc    <= 8'h00;
         cout_q <= 1'b0;
         cnt    <= Len;
      end else if (beat) begin
         acc    <= acc_beat;
         cout_q <= cout_q | sum9[8];
         cnt    <= cnt - LEN_W'(1);
      end
   end

   assign Sum  = acc;
   assign Cout = cout_q;

endmodule

// File: tb/tb_accum_8bit_seq.sv
// Self-checking bench for accum_8bit_seq: directed table, corner sequences,
// and randomized runs against a plain-arithmetic reference.
module tb_accum_8bit_seq;

   logic       Clk;
   logic       Rst_n;
   logic       Start;
   logic [3:0] Len;
   logic       In_valid;
   logic [7:0] In_data;
   logic       In_ready;
   logic [7:0] Sum;
   logic       Cout;
   logic       Done;
   logic       Busy;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] op_buf [16];

   typedef struct {
      string            name;
      int               len;
      int               gap;
      logic [15:0][7:0] ops;
      logic [7:0]       exp_sum;
      logic             exp_cout;
   } vec_t;

   vec_t vecs [4];

   accum_8bit_seq #(.LEN_W(4)) dut (
      .Clk      (Clk),
      .Rst_n    (Rst_n),
      .Start    (Start),
      .Len      (Len),
      .In_valid (In_valid),
      .In_data  (In_data),
      .In_ready (In_ready),
      .Sum      (Sum),
      .Cout     (Cout),
      .Done     (Done),
      .Busy     (Busy)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Starts a run at a negedge, feeds op_buf with `gap` idle cycles
   // between beats, and checks Done timing and the result.
   task automatic run_case(input string nm, input int len, input int gap,
                           input logic [7:0] exp_sum, input logic exp_cout);
      int beats, gcnt, cyc, dones, done_cyc, last_cyc;
      bit rdy_seen;
      logic [7:0] sum_d;
      logic cout_d, busy_d, busy_after;
      beats = 0; gcnt = 0; dones = 0;
      done_cyc = -1; last_cyc = -1; rdy_seen = 0;
      sum_d = 'x; cout_d = 'x; busy_d = 'x; busy_after = 'x;
      Start = 1'b1;
      Len = 4'(len);
      In_valid = 1'b0;
      @(negedge Clk);
      Start = 1'b0;
      cyc = 0;
      while (cyc < 300 && !(dones > 0 && cyc > done_cyc + 1)) begin
         if (Done) begin
            dones++;
            if (done_cyc < 0) begin
               done_cyc = cyc;
               sum_d = Sum;
               cout_d = Cout;
               busy_d = Busy;
            end
         end
         if (In_ready) rdy_seen = 1;
         if (done_cyc >= 0 && cyc == done_cyc + 1) busy_after = Busy;
         In_valid = 1'b0;
         In_data = 8'($urandom);
         if (beats < len && gcnt == 0) begin
            In_valid = 1'b1;
            In_data = op_buf[beats];
         end
         if (In_valid && In_ready) begin
            beats++;
            gcnt = gap;
            last_cyc = cyc;
         end else if (gcnt > 0) begin
            gcnt--;
         end
         @(negedge Clk);
         cyc++;
      end
      In_valid = 1'b0;
      chk({nm, " done count"}, dones, 1);
      chk({nm, " done cycle"}, done_cyc, (len == 0) ? 0 : last_cyc + 1);
      chk({nm, " sum"}, sum_d, exp_sum);
      chk({nm, " cout"}, cout_d, exp_cout);
      chk({nm, " busy at done"}, busy_d, 1);
      chk({nm, " busy after"}, busy_after, 0);
      chk({nm, " sum held"}, Sum, exp_sum);
      if (len == 0) chk({nm, " ready seen"}, rdy_seen, 0);
      else chk({nm, " beats"}, beats, len);
   endtask

   initial begin
      Rst_n = 1'b1; Start = 1'b0; Len = '0;
      In_valid = 1'b0; In_data = '0;
      #1 Rst_n = 1'b0;
      #1;
      chk("reset sum", Sum, 8'h00);
      chk("reset cout", Cout, 0);
      chk("reset done", Done, 0);
      chk("reset ready", In_ready, 0);
      chk("reset busy", Busy, 0);
      @(negedge Clk);
      Rst_n = 1'b1;

      vecs[0] = '{"basic", 3, 0, '0, 8'h06, 1'b0};
      vecs[0].ops[0] = 8'h01; vecs[0].ops[1] = 8'h02; vecs[0].ops[2] = 8'h03;
`ifdef ACCUM_SATURATE_EN
      vecs[1] = '{"carry", 2, 0, '0, 8'hFF, 1'b1};
`else
      vecs[1] = '{"carry", 2, 0, '0, 8'h01, 1'b1};
`endif
      vecs[1].ops[0] = 8'hFF; vecs[1].ops[1] = 8'h02;
      vecs[2] = '{"gaps", 4, 2, '0, 8'h40, 1'b0};
      for (int j = 0; j < 4; j++) vecs[2].ops[j] = 8'h10;
      vecs[3] = '{"len0", 0, 0, '0, 8'h00, 1'b0};

      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < 16; j++) op_buf[j] = vecs[i].ops[j];
         run_case(vecs[i].name, vecs[i].len, vecs[i].gap,
                  vecs[i].exp_sum, vecs[i].exp_cout);
      end

      // Start held high across two runs
      Start = 1'b1; Len = 4'd2;
      @(negedge Clk);
      Len = 4'd1;
      chk("b2b ready", In_ready, 1);
      In_valid = 1'b1; In_data = 8'h81;
      @(negedge Clk);
      In_data = 8'h81;
      @(negedge Clk);
      In_valid = 1'b0;
      chk("b2b r1 done", Done, 1);
      chk("b2b r1 sum", Sum, 8'h02);
      chk("b2b r1 cout", Cout, 1);
      @(negedge Clk);
      chk("b2b gap busy", Busy, 0);
      chk("b2b gap done", Done, 0);
      @(negedge Clk);
      chk("b2b r2 ready", In_ready, 1);
      In_valid = 1'b1; In_data = 8'h30;
      @(negedge Clk);
      In_valid = 1'b0;
      chk("b2b r2 done", Done, 1);
      chk("b2b r2 sum", Sum, 8'h30);
      chk("b2b r2 cout", Cout, 0);
      Start = 1'b0;
      @(negedge Clk);
      @(negedge Clk);
      chk("b2b end busy", Busy, 0);
      chk("b2b end sum", Sum, 8'h30);

      // Reset in the middle of an accumulation
      Start = 1'b1; Len = 4'd4;
      @(negedge Clk);
      Start = 1'b0; In_valid = 1'b1; In_data = 8'hFF;
      @(negedge Clk);
      In_data = 8'h05;
      @(negedge Clk);
      In_valid = 1'b0;
      chk("rst pre busy", Busy, 1);
      chk("rst pre cout", Cout, 1);
      #2 Rst_n = 1'b0;
      #1;
      chk("rst mid sum", Sum, 8'h00);
      chk("rst mid cout", Cout, 0);
      chk("rst mid busy", Busy, 0);
      chk("rst mid ready", In_ready, 0);
      chk("rst mid done", Done, 0);
      @(negedge Clk);
      chk("rst hold done", Done, 0);
      Start = 1'b1; Len = 4'd1; Rst_n = 1'b1;
      @(negedge Clk);
      chk("rst restart busy", Busy, 1);
      chk("rst restart ready", In_ready, 1);
      Start = 1'b0; In_valid = 1'b1; In_data = 8'h07;
      @(negedge Clk);
      In_valid = 1'b0;
      chk("rst restart done", Done, 1);
      chk("rst restart sum", Sum, 8'h07);
      chk("rst restart cout", Cout, 0);
      @(negedge Clk);

      // Randomized runs against the arithmetic reference
      for (int r = 0; r < 25; r++) begin
         int len, gap, total;
         logic [7:0] es;
         len = (r == 0) ? 15 : int'($urandom_range(0, 15));
         gap = int'($urandom_range(0, 2));
         total = 0;
         for (int j = 0; j < 16; j++) begin
            op_buf[j] = (r % 3 == 0) ? 8'($urandom_range(200, 255))
                                     : 8'($urandom);
            if (j < len) total += int'(op_buf[j]);
         end
`ifdef ACCUM_SATURATE_EN
         es = (total > 255) ? 8'hFF : 8'(total);
`else
         es = 8'(total % 256);
`endif
         run_case($sformatf("rand%0d", r), len, gap, es, total > 255);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/accum_8bit_seq.md
ACCUM_8BIT_SEQ -- requirements
Module: accum_8bit_seq

Interface
REQ-001 The block SHALL have parameter LEN_W, default 4, giving the width of the operand-count input.
REQ-002 The block SHALL have port Clk, input, 1, the single clock; all state SHALL change on its rising edge.
REQ-003 The block SHALL have port Rst_n, input, 1, the asynchronous active-low reset.
REQ-004 The block SHALL have port Start, input, 1, a request to begin an accumulation; it is sampled only in IDLE.
REQ-005 The block SHALL have port Len, input, LEN_W, the number of operands to sum; it is captured on an accepted Start.
REQ-006 The block SHALL have port In_valid, input, 1, which qualifies In_data.
REQ-007 The block SHALL have port In_data, input, 8, the operand, which is the Sum output of the upstream 8-bit adder.
REQ-008 The block SHALL have port In_ready, output, 1, indicating that the block accepts an operand this cycle.
REQ-009 The block SHALL have port Sum, output, 8, the accumulated result.
REQ-010 The block SHALL have port Cout, output, 1, a sticky carry that is 1 if any addition in the current run carried out of bit 7.
REQ-011 The block SHALL have port Done, output, 1, a one-cycle pulse marking that the result is final.
REQ-012 The block SHALL have port Busy, output, 1, which is high in ACCUM and DONE.

Function
REQ-013 The FSM SHALL have three states, IDLE, ACCUM and DONE, with IDLE as the reset state.
REQ-014 In IDLE, In_ready=0 and Busy=0, and Sum/Cout SHALL hold the last result.
REQ-015 Start=1 in IDLE SHALL, on that edge, clear the accumulator and Cout to 0 and load the remaining count with Len.
- If Len!=0, the FSM SHALL go to ACCUM.
- If Len=0, the FSM SHALL go directly to DONE, giving Sum=0.
REQ-016 In ACCUM, In_ready SHALL be 1 combinationally from the state alone; In_ready SHALL NOT depend on In_valid.
REQ-017 A beat is In_valid&In_ready at the rising edge; on a beat, {carry,acc} SHALL become acc+In_data as a 9-bit sum.
- Cout SHALL be set to Cout|carry.
- The remaining count SHALL be decremented.
REQ-018 Cycles with In_valid=0 in ACCUM SHALL leave all state unchanged, with no timeout.
REQ-019 On the beat that takes the remaining count from 1 to 0, the FSM SHALL go to DONE.
REQ-020 Done SHALL be 1 for exactly one cycle, the cycle after the last beat.
- Sum and Cout SHALL be final in that cycle.
- The FSM SHALL then return to IDLE unconditionally.
REQ-021 Start asserted in ACCUM or DONE SHALL be ignored; the block SHALL NOT queue it.
REQ-022 Start asserted in the cycle after DONE (IDLE) SHALL be accepted, so back-to-back runs take Len+2 cycles each.
REQ-023 With Len = 2^LEN_W-1 (15 by default), 15 beats SHALL be accepted with no count wrap.
REQ-024 Without saturation, Sum SHALL be the operand total modulo 256.
REQ-025 Sum SHALL be driven directly from a register, with no combinational path from In_data.

Reset
REQ-026 Rst_n=0 SHALL, asynchronously, force the state to IDLE, the accumulator and Sum to 0x00, Cout=0, Done=0, In_ready=0, Busy=0, and the count to 0.
REQ-027 Reset mid-run SHALL abandon the run with no Done pulse.
REQ-028 The block SHALL accept Start on the first rising edge after Rst_n deasserts.

Configuration
REQ-029 The macro ACCUM_SATURATE_EN SHALL control saturation.
- Defined: any beat that produces carry=1, or any beat while acc=0xFF, SHALL leave acc=0xFF; Cout behaves as in REQ-017.
- Undefined: the accumulator SHALL wrap modulo 256 as in REQ-024, and no saturation logic SHALL be present.

Verification
REQ-030 The bench SHALL check the following Reset case: assert Rst_n=0 mid-ACCUM -> immediate IDLE, Sum=0x00, Cout=0, no Done, and Start on the next edge is accepted.
REQ-031 The bench SHALL check the following Basic run case: Len=3, operands 0x01, 0x02, 0x03 on consecutive cycles -> Done on the cycle after the third beat, Sum=0x06, Cout=0.
REQ-032 The bench SHALL check the following Carry case: Len=2, operands 0xFF, 0x02 -> Cout=1, and Sum=0x01 without the macro or 0xFF with ACCUM_SATURATE_EN.
REQ-033 The bench SHALL check the following Gaps case: Len=4, operand 0x10 each, with In_valid low for 2 cycles between beats -> Sum=0x40, and Done exactly once.
REQ-034 The bench SHALL check the following Len=0 case: Start with Len=0 -> Done on the next cycle, Sum=0x00, In_ready never high.
REQ-035 The bench SHALL check the following Back-to-back and ignored-Start case: Start held high throughout two runs (Len=2: 0x81+0x81, then Len=1: 0x30) -> run 1 gives Sum=0x02, Cout=1; run 2 starts the cycle after Done and gives Sum=0x30, Cout=0; Start during ACCUM has no effect.
